// File: rtl/hazard_md_ctrl_if.sv
// Instruction and control bundle between the pipeline datapath and hazard_md_ctrl.
// The datapath drives the D/E/M instructions; the controller drives enables, clears and MD status.
interface hazard_md_ctrl_if;
  logic [31:0] ir_d;
  logic [31:0] ir_e;
  logic [31:0] ir_m;
  logic        en_pc;
  logic        en_fd;
  logic        clr_de;
  logic        md_start;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output ir_d, ir_e, ir_m,
    input  en_pc, en_fd, clr_de, md_start, md_busy, stall_cnt
  );

  modport slave (
    input  ir_d, ir_e, ir_m,
    output en_pc, en_fd, clr_de, md_start, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_md_ctrl.sv
// Hazard detection and mult/div scheduling for the 5-stage pipeline.
// Optional stall statistics counter is built when HAZARD_MD_CTRL_STATS_EN is defined.
module hazard_md_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input logic             clk,
  input logic             reset,
  hazard_md_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LAT);

  function automatic logic is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic logic is_md_start(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn inside {[6'h18 : 6'h1b]});
  endfunction

  logic [5:0] op_d, op_e, op_m, fn_d, fn_e;
  logic [4:0] rs_d, rt_d, rt_e, rd_e, rt_m;

  assign op_d = bus.ir_d[31:26];
  assign rs_d = bus.ir_d[25:21];
  assign rt_d = bus.ir_d[20:16];
  assign fn_d = bus.ir_d[5:0];
  assign op_e = bus.ir_e[31:26];
  assign rt_e = bus.ir_e[20:16];
  assign rd_e = bus.ir_e[15:11];
  assign fn_e = bus.ir_e[5:0];
  assign op_m = bus.ir_m[31:26];
  assign rt_m = bus.ir_m[20:16];

  logic unused_ir;
  assign unused_ir = ^{bus.ir_d[15:6], bus.ir_e[25:21], bus.ir_e[10:6], bus.ir_m[25:21],
                       bus.ir_m[15:0]};

  logic load_e, load_m, md_start, div_e, md_class_d, branch_d, br_rt_d;
  logic reads_rs_d, reads_rt_d;

  assign load_e     = is_load(op_e);
  assign load_m     = is_load(op_m);
  assign md_start   = is_md_start(op_e, fn_e);
  assign div_e      = fn_e[1];
  assign md_class_d = (op_d == 6'h00) &&
                      ((fn_d inside {[6'h10 : 6'h13]}) || (fn_d inside {[6'h18 : 6'h1b]}));
  assign br_rt_d    = (op_d == 6'h04) || (op_d == 6'h05);
  assign branch_d   = br_rt_d || ((op_d == 6'h00) && ((fn_d == 6'h08) || (fn_d == 6'h09)));
  assign reads_rs_d = !(op_d inside {6'h02, 6'h03, 6'h0f}) &&
                      !((op_d == 6'h00) && ((fn_d == 6'h10) || (fn_d == 6'h12)));
  assign reads_rt_d = op_d inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2b};

  // A destination of zero doubles as "no destination" since $0 never matches.
  logic [4:0] dest_e;
  always_comb begin
    dest_e = 5'd0;
    if (op_e == 6'h00) begin
      if (!(md_start || fn_e == 6'h11 || fn_e == 6'h13 || fn_e == 6'h08)) dest_e = rd_e;
    end else if ((op_e inside {[6'h08 : 6'h0f]}) || load_e) begin
      dest_e = rt_e;
    end else if (op_e == 6'h03) begin
      dest_e = 5'd31;
    end
  end

  logic stall_lu, stall_br, stall_md, stall, hit_e, hit_m;
  logic [CNT_W-1:0] cnt_q;

  assign stall_lu = load_e && (rt_e != 5'd0) &&
                    ((reads_rs_d && (rs_d == rt_e)) || (reads_rt_d && (rt_d == rt_e)));
  assign hit_e    = (dest_e != 5'd0) && ((rs_d == dest_e) || (br_rt_d && (rt_d == dest_e)));
  assign hit_m    = load_m && (rt_m != 5'd0) &&
                    ((rs_d == rt_m) || (br_rt_d && (rt_d == rt_m)));
  assign stall_br = branch_d && (hit_e || hit_m);
  assign stall_md = md_class_d && (md_start || bus.md_busy);
  assign stall    = stall_lu || stall_br || stall_md;

  // E never stalls, so a new start may reload over a running countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (md_start) begin
      cnt_q <= div_e ? DivLoad : MultLoad;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.md_start = md_start;
  assign bus.md_busy  = (cnt_q != '0);
  assign bus.en_pc    = !stall;
  assign bus.en_fd    = !stall;
  assign bus.clr_de   = stall;

`ifdef HAZARD_MD_CTRL_STATS_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hffff_ffff)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule
